// File: rtl/cla_32.sv
// cla_32 : registered 32-bit carry-lookahead adder, adder core of the CP-1 ALU.
//
// The block computes A + B + Cin with a two-level lookahead carry network:
//   - eight 4-bit groups;
//   - one lookahead unit over the group (G, P) pairs.
// It also exposes the per-bit generate and propagate vectors and two result
// flags. Every output is registered, so results appear one clock after the
// operands are sampled.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   A, B       in  32   operands (two's complement or unsigned)
//   Cin        in   1   carry into bit 0
//   S          out 32   registered sum, A + B + Cin mod 2^32
//   Cout       out  1   registered carry out of bit 31
//   bw_and     out 32   registered A & B (per-bit generate)
//   bw_or      out 32   registered A | B (per-bit propagate)
//   isZero     out  1   registered flag, S == 0 (1 during reset)
//   isNegative out  1   registered flag, S[31]
module cla_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout,
  output logic [31:0] bw_and,
  output logic [31:0] bw_or,
  output logic        isZero,
  output logic        isNegative
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] x;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  // grp_c[k] is the carry into group k; grp_c[8] is the carry out of bit 31.
  logic [8:0]  grp_c;
  logic [32:0] c;

  logic [31:0] s_d, s_q;
  logic        cout_d, cout_q;
  logic [31:0] bw_and_d, bw_and_q;
  logic [31:0] bw_or_d, bw_or_q;
  logic        is_zero_d, is_zero_q;
  logic        is_negative_d, is_negative_q;

  // Per-bit generate/propagate, plus the group-level (G, P) of each nibble.
  // p uses OR rather than XOR; that is valid for carries because g covers
  // the case where both bits are set. The sum uses x (the XOR) instead.
  always_comb begin
    g     = A & B;
    p     = A | B;
    x     = A ^ B;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Second-level lookahead. Each group carry-in is a flat sum of products:
  //   c[4k] = G[k-1] | P[k-1]G[k-2] | ... | P[k-1]..P[0] Cin.
  // The loops unroll into independent product terms; no carry passes from
  // one group's result into the next group's equation.
  always_comb begin
    logic acc;
    logic term;
    grp_c    = '0;
    grp_c[0] = Cin;
    for (int k = 1; k <= 8; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      term = Cin;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k] = acc | term;
    end
  end

  // First-level lookahead inside each nibble. Every internal carry is
  // computed directly from that nibble's p/g and its group carry-in.
  // The block also forms the next register values.
  always_comb begin
    logic acc;
    logic term;
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k] = grp_c[k];
      for (int i = 1; i < 4; i++) begin
        acc = 1'b0;
        for (int j = 0; j < i; j++) begin
          term = g[4*k+j];
          for (int m = j + 1; m < i; m++) begin
            term = term & p[4*k+m];
          end
          acc = acc | term;
        end
        term = grp_c[k];
        for (int m = 0; m < i; m++) begin
          term = term & p[4*k+m];
        end
        c[4*k+i] = acc | term;
      end
    end
    c[32] = grp_c[8];

    s_d           = x ^ c[31:0];
    cout_d        = c[32];
    bw_and_d      = g;
    bw_or_d       = p;
    // Flags come from the new sum so they line up with S in the same cycle.
    is_zero_d     = ~|s_d;
    is_negative_d = s_d[31];
  end

  // Output registers. Reset clears the result; isZero is set so that it
  // stays consistent with S = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q           <= '0;
      cout_q        <= 1'b0;
      bw_and_q      <= '0;
      bw_or_q       <= '0;
      is_zero_q     <= 1'b1;
      is_negative_q <= 1'b0;
    end else begin
      s_q           <= s_d;
      cout_q        <= cout_d;
      bw_and_q      <= bw_and_d;
      bw_or_q       <= bw_or_d;
      is_zero_q     <= is_zero_d;
      is_negative_q <= is_negative_d;
    end
  end

  assign S          = s_q;
  assign Cout       = cout_q;
  assign bw_and     = bw_and_q;
  assign bw_or      = bw_or_q;
  assign isZero     = is_zero_q;
  assign isNegative = is_negative_q;

endmodule

// File: tb/tb_cla_32.sv
// tb_cla_32 : testbench for cla_32 using directed vectors with hand-computed
// results and a back-to-back random stream checked against a 33-bit golden sum.
module tb_cla_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic [31:0] bw_and;
  logic [31:0] bw_or;
  logic        isZero;
  logic        isNegative;

  int assertCount = 0;
  int failCount   = 0;

  cla_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .Cin        (Cin),
    .S          (S),
    .Cout       (Cout),
    .bw_and     (bw_and),
    .bw_or      (bw_or),
    .isZero     (isZero),
    .isNegative (isNegative)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one vector at the falling edge. The vector is captured on the
  // next rising edge, and the task samples 1 ns after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic expectResult(input string tag, input logic [31:0] s,
                              input logic cout, input logic [31:0] band,
                              input logic [31:0] bor, input logic z,
                              input logic n);
    checkOutput({tag, "_S"},      64'(S),          64'(s));
    checkOutput({tag, "_Cout"},   64'(Cout),       64'(cout));
    checkOutput({tag, "_bw_and"}, 64'(bw_and),     64'(band));
    checkOutput({tag, "_bw_or"},  64'(bw_or),      64'(bor));
    checkOutput({tag, "_isZero"}, 64'(isZero),     64'(z));
    checkOutput({tag, "_isNeg"},  64'(isNegative), 64'(n));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] golden;

    rst_n = 1'b0;
    A     = 32'h0;
    B     = 32'h0;
    Cin   = 1'b0;

    // Reset state.
    #12;
    expectResult("reset_init", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Inputs applied while reset is held must not load on the clock edge.
    A = 32'h12345678;
    B = 32'h11111111;
    @(posedge clk);
    #1;
    expectResult("reset_hold", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Release reset between clock edges. The next edge loads the current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectResult("post_reset", 32'h23456789, 1'b0, 32'h10101010,
                 32'h13355779, 1'b0, 1'b0);

    // Assert reset mid-cycle with nonzero inputs. The test waits no edge.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    expectResult("all_ones", 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expectResult("async_reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full carry chain.
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1);
    expectResult("full_carry", 32'h0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Signed cancel: -450000 + 450000.
    applyStimulus(32'hFFF92230, 32'h0006DDD0, 1'b0);
    expectResult("signed_cancel", 32'h0, 1'b1, 32'h00000010,
                 32'hFFFFFFF0, 1'b1, 1'b0);

    // Sign boundary.
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0);
    expectResult("sign_boundary", 32'h80000000, 1'b0, 32'h00000001,
                 32'h7FFFFFFF, 1'b0, 1'b1);

    // Group boundaries.
    applyStimulus(32'h0000000F, 32'h00000001, 1'b0);
    expectResult("group0_cross", 32'h00000010, 1'b0, 32'h00000001,
                 32'h0000000F, 1'b0, 1'b0);
    applyStimulus(32'h0FFFFFFF, 32'h00000001, 1'b0);
    expectResult("groups_cross", 32'h10000000, 1'b0, 32'h00000001,
                 32'h0FFFFFFF, 1'b0, 1'b0);
    applyStimulus(32'h000000FF, 32'h00000000, 1'b1);
    expectResult("cin_cross", 32'h00000100, 1'b0, 32'h00000000,
                 32'h000000FF, 1'b0, 1'b0);

    // Back-to-back random regression, one new vector every cycle.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra;
      applyStimulus(ra, rb, rc);
      golden = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      expectResult($sformatf("rand%0d", i), golden[31:0], golden[32],
                   ra & rb, ra | rb, golden[31:0] == 32'h0, golden[31]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
